// File: rtl/ccd_afe_pkg.sv
// Shared types, constants and helpers for the linear-CCD AFE line controller.
package ccd_afe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DUMMY  = 2'd1,
        ST_OB     = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    // Default timing shared with the CCD timing generator
    localparam int unsigned DEF_D_WIDTH      = 16;
    localparam int unsigned DEF_SAMP_NUM     = 2048;
    localparam int unsigned DEF_DUMMY_NUM    = 10;
    localparam int unsigned DEF_OB_NUM       = 16;
    localparam int unsigned DEF_RS_LOW_WIDTH = 10;
    localparam int unsigned DEF_RS_DLY_NUM   = 2;
    localparam int unsigned DEF_F2_DLY_NUM   = 2;
    localparam int unsigned DEF_LCNT_W       = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/ccd_dly_line.sv
// Fixed-depth shift register with synchronous active-low clear.
module ccd_dly_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign sr_d = d_i;
        end else begin : g_multi
            assign sr_d = {sr_q[DEPTH-2:0], d_i};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) sr_q <= '0;
        else          sr_q <= sr_d;
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ccd_afe_line_ctrl.sv
// AFE clock generation and per-line dummy/OB/active sequencing for a linear CCD.
module ccd_afe_line_ctrl
    import ccd_afe_pkg::*;
#(
    parameter int unsigned D_WIDTH      = DEF_D_WIDTH,
    parameter int unsigned SAMP_NUM     = DEF_SAMP_NUM,
    parameter int unsigned DUMMY_NUM    = DEF_DUMMY_NUM,
    parameter int unsigned OB_NUM       = DEF_OB_NUM,
    parameter int unsigned RS_LOW_WIDTH = DEF_RS_LOW_WIDTH,
    parameter int unsigned RS_DLY_NUM   = DEF_RS_DLY_NUM,
    parameter int unsigned F2_DLY_NUM   = DEF_F2_DLY_NUM,
    parameter int unsigned LCNT_W       = DEF_LCNT_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               sh,
    input  logic               f2,
    input  logic               rs,
    input  logic               ob_en,
    input  logic [D_WIDTH-1:0] DATA_IN,
    output logic               SHP,
    output logic               SHD,
    output logic               DATACLK,
    output logic [D_WIDTH-1:0] tdata,
    output logic               tvalid,
    output logic               tuser,
    output logic               tlast,
    output logic [D_WIDTH-1:0] ob_level,
    output logic [LCNT_W-1:0]  line_cnt,
    output logic               overrun
);

    localparam int unsigned OB_LOG  = clog2(OB_NUM);
    localparam int unsigned ACC_W   = D_WIDTH + OB_LOG;
    localparam int unsigned MAX_NUM = (SAMP_NUM > DUMMY_NUM)
        ? ((SAMP_NUM > OB_NUM) ? SAMP_NUM : OB_NUM)
        : ((DUMMY_NUM > OB_NUM) ? DUMMY_NUM : OB_NUM);
    localparam int unsigned PIX_RAW = clog2(MAX_NUM) + 1;
    localparam int unsigned PIX_W   = (PIX_RAW > 12) ? PIX_RAW : 12;

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [D_WIDTH-1:0] ob_level_q, ob_level_d;
    logic [D_WIDTH-1:0] tdata_q, tdata_d;
    logic [LCNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic               tvalid_q, tvalid_d;
    logic               tuser_q, tuser_d;
    logic               tlast_q, tlast_d;
    logic               overrun_q, overrun_d;
    logic               sh_q, f2_q;
    logic               sh_rise, f2_rise;

    assign sh_rise = sh & ~sh_q;
    assign f2_rise = f2 & ~f2_q;
    assign acc_sum = acc_q + ACC_W'(DATA_IN);

    // Free-running AFE clocks, independent of line state
    ccd_dly_line #(.DEPTH(RS_DLY_NUM + 1)) u_rs_dly (
        .clk_i(sys_clk), .rst_n_i(sys_rst_n), .d_i(~rs), .q_o(SHP)
    );
    ccd_dly_line #(.DEPTH(RS_LOW_WIDTH + 1)) u_shp_dly (
        .clk_i(sys_clk), .rst_n_i(sys_rst_n), .d_i(SHP), .q_o(SHD)
    );
    ccd_dly_line #(.DEPTH(F2_DLY_NUM + 1)) u_f2_dly (
        .clk_i(sys_clk), .rst_n_i(sys_rst_n), .d_i(~f2), .q_o(DATACLK)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            acc_q      <= '0;
            ob_level_q <= '0;
            tdata_q    <= '0;
            line_cnt_q <= '0;
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sh_q       <= 1'b0;
            f2_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            acc_q      <= acc_d;
            ob_level_q <= ob_level_d;
            tdata_q    <= tdata_d;
            line_cnt_q <= line_cnt_d;
            tvalid_q   <= tvalid_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            overrun_q  <= overrun_d;
            sh_q       <= sh;
            f2_q       <= f2;
        end
    end

    // A new line start preempts everything, including a coincident pixel
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        acc_d      = acc_q;
        ob_level_d = ob_level_q;
        tdata_d    = tdata_q;
        line_cnt_d = line_cnt_q;
        tvalid_d   = 1'b0;
        tuser_d    = 1'b0;
        tlast_d    = 1'b0;
        overrun_d  = 1'b0;

        if (sh_rise) begin
            overrun_d = (state_q != ST_IDLE);
            state_d   = ST_DUMMY;
            pix_cnt_d = '0;
        end else if (f2_rise) begin
            case (state_q)
                ST_DUMMY: begin
                    if (pix_cnt_q == PIX_W'(DUMMY_NUM - 1)) begin
                        state_d   = ST_OB;
                        pix_cnt_d = '0;
                        acc_d     = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
                ST_OB: begin
                    if (pix_cnt_q == PIX_W'(OB_NUM - 1)) begin
                        ob_level_d = D_WIDTH'(acc_sum >> OB_LOG);
                        state_d    = ST_ACTIVE;
                        pix_cnt_d  = '0;
                    end else begin
                        acc_d     = acc_sum;
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    tvalid_d = 1'b1;
                    tdata_d  = ob_en ? D_WIDTH'(sat_sub(32'(DATA_IN), 32'(ob_level_q))) : DATA_IN;
                    tuser_d  = (pix_cnt_q == '0);
                    tlast_d  = (pix_cnt_q == PIX_W'(SAMP_NUM - 1));
                    if (pix_cnt_q == PIX_W'(SAMP_NUM - 1)) begin
                        state_d    = ST_IDLE;
                        pix_cnt_d  = '0;
                        line_cnt_d = line_cnt_q + LCNT_W'(1);
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tdata    = tdata_q;
    assign tvalid   = tvalid_q;
    assign tuser    = tuser_q;
    assign tlast    = tlast_q;
    assign ob_level = ob_level_q;
    assign line_cnt = line_cnt_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_ccd_afe_line_ctrl.sv
// Randomised and directed bench for ccd_afe_line_ctrl with a line-level reference model.
module tb_ccd_afe_line_ctrl;

    localparam int DW  = 16;
    localparam int SN  = 8;
    localparam int DN  = 10;
    localparam int ON  = 16;
    localparam int RLW = 10;
    localparam int RDN = 2;
    localparam int FDN = 2;
    localparam int LW  = 4;
    localparam int D1  = RDN + 1;
    localparam int D2  = RLW + 1;
    localparam int D3  = FDN + 1;
    localparam int HN  = 16384;

    logic          clk = 1'b0;
    logic          rst_n, sh, f2, rs, ob_en;
    logic [DW-1:0] din;
    logic          SHP, SHD, DATACLK, tvalid, tuser, tlast, overrun;
    logic [DW-1:0] tdata, ob_level;
    logic [LW-1:0] line_cnt;

    int checks = 0;
    int failures = 0;
    bit rs_free = 0;

    ccd_afe_line_ctrl #(
        .D_WIDTH(DW), .SAMP_NUM(SN), .DUMMY_NUM(DN), .OB_NUM(ON),
        .RS_LOW_WIDTH(RLW), .RS_DLY_NUM(RDN), .F2_DLY_NUM(FDN), .LCNT_W(LW)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .sh(sh), .f2(f2), .rs(rs),
        .ob_en(ob_en), .DATA_IN(din), .SHP(SHP), .SHD(SHD), .DATACLK(DATACLK),
        .tdata(tdata), .tvalid(tvalid), .tuser(tuser), .tlast(tlast),
        .ob_level(ob_level), .line_cnt(line_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  ecnt = 0;
    int  last_rst = 0;
    bit  nrs_h [HN];
    bit  nf2_h [HN];
    bit  m_prev_sh, m_prev_f2, m_in_line;
    int  m_n, m_sum, m_ob, m_lc, k, v;
    logic          e_shp, e_shd, e_dclk, e_tv, e_tu, e_tl, e_ov;
    logic [DW-1:0] e_td, e_ob;
    logic [LW-1:0] e_lc;

    function automatic bit hist(input bit is_rs, input int idx);
        if (idx < 1 || idx <= last_rst) return 1'b0;
        return is_rs ? nrs_h[idx] : nf2_h[idx];
    endfunction

    always @(posedge clk) begin
        ecnt++;
        if (ecnt < HN) begin
            nrs_h[ecnt] = ~rs;
            nf2_h[ecnt] = ~f2;
        end
        e_tv = 0; e_tu = 0; e_tl = 0; e_ov = 0;
        if (!rst_n) begin
            last_rst = ecnt;
            m_prev_sh = 0; m_prev_f2 = 0; m_in_line = 0;
            m_ob = 0; m_lc = 0; m_n = 0; m_sum = 0;
            e_td = '0;
        end else begin
            if (sh && !m_prev_sh) begin
                e_ov = m_in_line;
                m_in_line = 1; m_n = 0; m_sum = 0;
            end else if (f2 && !m_prev_f2 && m_in_line) begin
                if (m_n >= DN && m_n < DN + ON) begin
                    m_sum += int'(din);
                    if (m_n == DN + ON - 1) m_ob = m_sum / ON;
                end else if (m_n >= DN + ON) begin
                    k = m_n - DN - ON;
                    v = int'(din);
                    e_tv = 1;
                    e_td = ob_en ? DW'((v > m_ob) ? v - m_ob : 0) : din;
                    e_tu = (k == 0);
                    e_tl = (k == SN - 1);
                    if (k == SN - 1) begin
                        m_in_line = 0;
                        m_lc = (m_lc + 1) % (1 << LW);
                    end
                end
                m_n++;
            end
            m_prev_sh = sh;
            m_prev_f2 = f2;
        end
        e_ob   = DW'(m_ob);
        e_lc   = LW'(m_lc);
        e_shp  = hist(1, ecnt - D1 + 1);
        e_shd  = hist(1, ecnt - D1 - D2 + 1);
        e_dclk = hist(0, ecnt - D3 + 1);
    end

    always @(negedge clk) begin
        if (ecnt > 0 && ecnt < HN) begin
            chk("SHP", 32'(SHP), 32'(e_shp));
            chk("SHD", 32'(SHD), 32'(e_shd));
            chk("DATACLK", 32'(DATACLK), 32'(e_dclk));
            chk("tvalid", 32'(tvalid), 32'(e_tv));
            chk("tuser", 32'(tuser), 32'(e_tu));
            chk("tlast", 32'(tlast), 32'(e_tl));
            chk("overrun", 32'(overrun), 32'(e_ov));
            chk("tdata", 32'(tdata), 32'(e_td));
            chk("ob_level", 32'(ob_level), 32'(e_ob));
            chk("line_cnt", 32'(line_cnt), 32'(e_lc));
        end
    end

    // ---------------- stimulus ----------------
    logic          b_tv, b_tu, b_tl;
    logic [DW-1:0] b_td;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rs_free && ($urandom % 3 == 0)) rs = ~rs;
    endtask

    task automatic pulse(input logic [DW-1:0] d, input logic oe);
        f2 = 1'b1; din = d; ob_en = oe;
        tick();
        b_tv = tvalid; b_td = tdata; b_tu = tuser; b_tl = tlast;
        f2 = 1'b0; din = DW'($urandom); ob_en = 1'($urandom);
        tick();
    endtask

    task automatic start_line();
        sh = 1'b1;
        tick();
        sh = 1'b0;
        tick();
    endtask

    task automatic run_line(input logic [DW-1:0] obv, input logic [DW-1:0] actv, input logic oe);
        start_line();
        repeat (DN) pulse(DW'($urandom), 1'b0);
        repeat (ON) pulse(obv, 1'b0);
        repeat (SN) pulse(actv, oe);
    endtask

    initial begin
        rst_n = 0; sh = 0; f2 = 0; rs = 1; ob_en = 0; din = '0;
        repeat (3) tick();
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_line_cnt", 32'(line_cnt), 0);
        chk("rst_ob_level", 32'(ob_level), 0);
        rst_n = 1;

        // clock delay pinning
        rs = 1; f2 = 1;
        repeat (20) tick();
        chk("dly_shp_idle", 32'(SHP), 0);
        chk("dly_dclk_idle", 32'(DATACLK), 0);
        rs = 0; f2 = 0;
        repeat (2) tick();
        chk("dly_shp_2", 32'(SHP), 0);
        chk("dly_dclk_2", 32'(DATACLK), 0);
        tick();
        chk("dly_shp_3", 32'(SHP), 1);
        chk("dly_dclk_3", 32'(DATACLK), 1);
        repeat (10) tick();
        chk("dly_shd_13", 32'(SHD), 0);
        tick();
        chk("dly_shd_14", 32'(SHD), 1);
        rs_free = 1;

        // normal line
        start_line();
        repeat (DN) pulse(DW'($urandom), 1'b0);
        repeat (ON) pulse(16'd100, 1'b0);
        chk("norm_ob_level", 32'(ob_level), 100);
        for (int i = 0; i < SN; i++) begin
            pulse(16'd500, 1'b1);
            chk("norm_tvalid", 32'(b_tv), 1);
            chk("norm_tdata", 32'(b_td), 400);
            chk("norm_tuser", 32'(b_tu), (i == 0) ? 1 : 0);
            chk("norm_tlast", 32'(b_tl), (i == SN - 1) ? 1 : 0);
        end
        chk("norm_line_cnt", 32'(line_cnt), 1);

        // saturation
        start_line();
        repeat (DN) pulse(DW'($urandom), 1'b0);
        repeat (ON) pulse(16'd100, 1'b0);
        pulse(16'd40, 1'b1);
        chk("sat_tdata_oben", 32'(b_td), 0);
        pulse(16'd40, 1'b0);
        chk("sat_tdata_raw", 32'(b_td), 40);
        repeat (SN - 2) pulse(DW'($urandom), 1'b1);
        chk("sat_line_cnt", 32'(line_cnt), 2);

        // abort during ACTIVE at pixel 3
        start_line();
        repeat (DN) pulse(DW'($urandom), 1'b0);
        repeat (ON) pulse(DW'($urandom), 1'b0);
        repeat (3) pulse(DW'($urandom), 1'b1);
        sh = 1'b1;
        tick();
        chk("abort_overrun", 32'(overrun), 1);
        chk("abort_tlast", 32'(tlast), 0);
        chk("abort_line_cnt", 32'(line_cnt), 2);
        sh = 1'b0;
        tick();
        chk("abort_overrun_end", 32'(overrun), 0);
        repeat (DN) pulse(DW'($urandom), 1'b0);
        repeat (ON) pulse(DW'($urandom), 1'b0);
        repeat (SN) pulse(DW'($urandom), 1'b1);
        chk("abort_new_tlast", 32'(b_tl), 1);
        chk("abort_new_line_cnt", 32'(line_cnt), 3);

        // sh and f2 rising together: that f2 is not a pixel
        sh = 1'b1; f2 = 1'b1;
        tick();
        sh = 1'b0; f2 = 1'b0;
        tick();
        repeat (DN) pulse(DW'($urandom), 1'b0);
        repeat (ON) pulse(DW'($urandom), 1'b0);
        pulse(DW'($urandom), 1'b0);
        chk("simul_first_tuser", 32'(b_tu), 1);
        repeat (SN - 2) pulse(DW'($urandom), 1'b0);
        chk("simul_line_cnt_pre", 32'(line_cnt), 3);
        pulse(DW'($urandom), 1'b0);
        chk("simul_tlast", 32'(b_tl), 1);
        chk("simul_line_cnt", 32'(line_cnt), 4);

        // f2 in IDLE produces nothing
        for (int i = 0; i < 4; i++) begin
            pulse(DW'($urandom), 1'b1);
            chk("idle_tvalid", 32'(b_tv), 0);
        end

        // reset mid-OB
        start_line();
        repeat (DN) pulse(DW'($urandom), 1'b0);
        repeat (5) pulse(DW'($urandom), 1'b0);
        rst_n = 0;
        tick();
        chk("mrst_overrun", 32'(overrun), 0);
        chk("mrst_tvalid", 32'(tvalid), 0);
        chk("mrst_tdata", 32'(tdata), 0);
        chk("mrst_ob_level", 32'(ob_level), 0);
        chk("mrst_line_cnt", 32'(line_cnt), 0);
        chk("mrst_shp", 32'(SHP), 0);
        chk("mrst_shd", 32'(SHD), 0);
        chk("mrst_dclk", 32'(DATACLK), 0);
        rst_n = 1;
        tick();

        // line counter wrap
        for (int i = 1; i <= 16; i++) begin
            run_line(DW'($urandom), DW'($urandom), 1'($urandom));
            if (i == 15) chk("wrap_15", 32'(line_cnt), 15);
        end
        chk("wrap_0", 32'(line_cnt), 0);

        // random traffic
        repeat (4000) begin
            sh    = ($urandom % 200 == 0);
            f2    = 1'($urandom);
            din   = DW'($urandom);
            ob_en = 1'($urandom);
            rst_n = ($urandom % 1500 != 0);
            tick();
        end
        rst_n = 1; sh = 0; f2 = 0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccd_afe_line_ctrl.md
Name: ccd_afe_line_ctrl

Overview:
- Second-generation AFE driver for linear CCD sensors.
- Generates SHP, SHD and DATACLK from the CCD timing pulses rs and f2.
- Sequences each line through dummy, optical-black (OB) and active pixel regions.
- Outputs a stream of active pixels with optional OB-level subtraction, line framing flags, a line counter and an aborted-line flag.
- Sits between the CCD timing generator and the pixel-processing datapath, on the same sys_clk.

Parameters:
- D_WIDTH, 16: ADC sample width in bits.
- SAMP_NUM, 2048: active pixels per line (>=1).
- DUMMY_NUM, 10: leading dummy pixels discarded per line (>=1).
- OB_NUM, 16: optical-black pixels averaged per line (power of two, >=1).
- RS_LOW_WIDTH, 10: rs low pulse width in sys_clk cycles.
- RS_DLY_NUM, 2: rs-to-SHP delay in cycles (>=1).
- F2_DLY_NUM, 2: f2-to-DATACLK delay in cycles (>=1).
- LCNT_W, 16: line counter width.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst_n, input, 1: reset, synchronous, active-low.
- sh, input, 1: CCD transfer-gate pulse; a rising edge starts a line.
- f2, input, 1: CCD shift pulse 2; a rising edge marks one pixel.
- rs, input, 1: CCD reset pulse.
- ob_en, input, 1: enables OB subtraction on active pixels.
- DATA_IN, input, D_WIDTH: ADC data.
- SHP, output, 1: AFE clamp clock.
- SHD, output, 1: AFE sample clock.
- DATACLK, output, 1: AFE data clock.
- tdata, output, D_WIDTH: pixel data.
- tvalid, output, 1: one-cycle pixel strobe.
- tuser, output, 1: first active pixel of the line.
- tlast, output, 1: last active pixel of the line.
- ob_level, output, D_WIDTH: current OB average.
- line_cnt, output, LCNT_W: count of completed lines.
- overrun, output, 1: one-cycle pulse when a line is aborted.

Behaviour:
- Reset: when sys_rst_n=0 at a clock edge, all registers and delay lines clear to 0. On the next cycle:
  - SHP, SHD, DATACLK, tvalid, tuser, tlast, overrun = 0.
  - ob_level = 0, line_cnt = 0, state = IDLE.
  - Reset mid-line discards that line silently: no overrun, no tlast.
- Edge detection: registered copies sh_q and f2_q.
  - sh_rise = sh & ~sh_q.
  - f2_rise = f2 & ~f2_q.
- Clock generation, free-running in every state:
  - SHP = ~rs delayed RS_DLY_NUM+1 cycles.
  - SHD = SHP delayed RS_LOW_WIDTH+1 further cycles.
  - DATACLK = ~f2 delayed F2_DLY_NUM+1 cycles.
- State machine: IDLE, DUMMY, OB, ACTIVE. pix_cnt is 12+ bits wide.
- sh_rise has priority over everything:
  - Any state goes to DUMMY with pix_cnt=0.
  - An f2_rise in the same cycle is ignored.
  - If the state was DUMMY, OB or ACTIVE, overrun pulses 1 cycle and line_cnt is unchanged.
- IDLE: f2_rise is ignored.
- DUMMY: each f2_rise increments pix_cnt. At pix_cnt=DUMMY_NUM-1, go to OB, clear pix_cnt, clear acc.
- OB: each f2_rise adds DATA_IN to acc (width D_WIDTH+log2(OB_NUM), no overflow possible). At the last OB pixel:
  - ob_level <= (acc+DATA_IN) >> log2(OB_NUM).
  - Go to ACTIVE, clear pix_cnt.
  - ob_level holds its value until the next completed OB region.
- ACTIVE: each f2_rise registers one output beat, visible the next cycle (1-cycle latency from the f2_rise detection edge):
  - tvalid=1.
  - tdata = ob_en ? max(DATA_IN - ob_level, 0) : DATA_IN. The subtraction saturates at 0 and never wraps.
  - tuser=1 when pix_cnt=0.
  - tlast=1 when pix_cnt=SAMP_NUM-1.
  - SAMP_NUM=1 gives tuser and tlast on the same beat.
- After the tlast beat: go to IDLE, line_cnt increments (wraps modulo 2^LCNT_W).
- ob_en and DATA_IN are sampled per pixel at the f2_rise edge.
- tvalid, tuser, tlast and overrun are single-cycle pulses. tdata holds its value between beats.
- No backpressure: downstream must accept every beat.

Decomposition:
- Package ccd_afe_pkg holds:
  - state enum type.
  - clog2 function.
  - saturating-subtract function.
  - Default timing constants shared with the CCD timing generator.
- Sub-module ccd_dly_line: parameterised shift register (DEPTH, synchronous active-low clear). Instantiated three times, for rs, SHP and f2.

Test Plan:
- Clock delays: toggle rs and f2 with no sh; RS_DLY_NUM=2, RS_LOW_WIDTH=10, F2_DLY_NUM=2 -> SHP = ~rs 3 cycles later, SHD = SHP 11 cycles later, DATACLK = ~f2 3 cycles later.
- Normal line: DUMMY_NUM=10, OB_NUM=16 with OB data 100, SAMP_NUM=8, active data 500, ob_en=1 -> ob_level=100; 8 beats of tdata=400; tuser on beat 0, tlast on beat 7; line_cnt 0->1.
- Saturation: ob_level=100, active DATA_IN=40, ob_en=1 -> tdata=0; with ob_en=0 -> tdata=40.
- Abort: sh_rise during ACTIVE at pixel 3 -> overrun pulses once, no tlast, line_cnt unchanged; the new line completes normally.
- Simultaneous and idle: sh_rise and f2_rise in the same cycle -> that f2 is not counted (11 f2 pulses needed to leave DUMMY); f2 pulses in IDLE -> no tvalid.
- Reset and wrap: sys_rst_n low mid-OB -> all outputs 0 next cycle, no overrun. LCNT_W=4 with 16 lines -> line_cnt wraps to 0.
